// File: rtl/vend_pkg.sv
// vend_pkg - shared types and constants for the vending machine dispense path.
//   vend_state_t       : dispense FSM states
//   COIN*_U            : coin values in 5-cent units
//   COIN_SEL_*         : one-hot coin select codes {coin25, coin10, coin5}
//   ITEM_* / PRICE_*   : product one-hot codes and prices in cents
//   is_onehot4()       : legal product-select test
//   units_to_cents()   : 5-cent units to binary cents for the display
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VEND   = 2'd1,
    ST_CHANGE = 2'd2,
    ST_DONE   = 2'd3
  } vend_state_t;

  localparam int COIN5_U  = 1;
  localparam int COIN10_U = 2;
  localparam int COIN25_U = 5;

  localparam logic [2:0] COIN_SEL_NONE = 3'b000;
  localparam logic [2:0] COIN_SEL_5    = 3'b001;
  localparam logic [2:0] COIN_SEL_10   = 3'b010;
  localparam logic [2:0] COIN_SEL_25   = 3'b100;

  localparam logic [3:0] ITEM_15C = 4'b0001;
  localparam logic [3:0] ITEM_20C = 4'b0010;
  localparam logic [3:0] ITEM_25C = 4'b0100;
  localparam logic [3:0] ITEM_30C = 4'b1000;

  localparam int PRICE_15C = 15;
  localparam int PRICE_20C = 20;
  localparam int PRICE_25C = 25;
  localparam int PRICE_30C = 30;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // x*5 as x*4 + x keeps this a shift-and-add rather than a multiplier.
  function automatic logic [7:0] units_to_cents(input logic [7:0] units);
    return (units << 2) + units;
  endfunction

endpackage

// File: rtl/vend_dispense_if.sv
// vend_dispense_if - request and status bundle between the coin-credit FSM
// (master) and the dispense stage (slave).
//   vend_req, item, change_units      : request from the credit FSM
//   busy, led, coin5/10/25,
//   change_left, done, err            : status back from the dispense stage
interface vend_dispense_if #(
  parameter int UNIT_W = 3
);

  logic              vend_req;
  logic [3:0]        item;
  logic [UNIT_W-1:0] change_units;
  logic              busy;
  logic [3:0]        led;
  logic              coin5;
  logic              coin10;
  logic              coin25;
  logic [7:0]        change_left;
  logic              done;
  logic              err;

  modport master (
    output vend_req, item, change_units,
    input  busy, led, coin5, coin10, coin25, change_left, done, err
  );

  modport slave (
    input  vend_req, item, change_units,
    output busy, led, coin5, coin10, coin25, change_left, done, err
  );

endinterface

// File: rtl/vend_dispense_coin_sel.sv
// change_coin_sel - combinational greedy coin chooser (25/10/5).
//   rem      : change still owed, in 5-cent units
//   coin_sel : one-hot {coin25, coin10, coin5}; none when rem is 0
//   rem_next : change owed after ejecting the selected coin
module change_coin_sel
  import vend_pkg::*;
#(
  parameter int UNIT_W = 3
) (
  input  logic [UNIT_W-1:0] rem,
  output logic [2:0]        coin_sel,
  output logic [UNIT_W-1:0] rem_next
);

  // rem == 0 selects nothing so a stray evaluation can never underflow.
  always_comb begin
    coin_sel = COIN_SEL_NONE;
    rem_next = rem;
    if (rem >= UNIT_W'(COIN25_U)) begin
      coin_sel = COIN_SEL_25;
      rem_next = rem - UNIT_W'(COIN25_U);
    end else if (rem >= UNIT_W'(COIN10_U)) begin
      coin_sel = COIN_SEL_10;
      rem_next = rem - UNIT_W'(COIN10_U);
    end else if (rem != '0) begin
      coin_sel = COIN_SEL_5;
      rem_next = rem - UNIT_W'(COIN5_U);
    end
  end

endmodule

// File: rtl/vend_dispense.sv
// vend_dispense - dispense stage of the vending machine.
// Accepts a one-cycle vend request, lights the product LED for HOLD_SEC
// ticks, then ejects change one coin per tick (greedy 25/10/5) and
// pulses done. Every output is registered.
//   clk_1Hz : system tick, rising edge
//   clr     : asynchronous active-high reset
//   bus     : vend_dispense_if slave (request in, status out)
// Parameters: HOLD_SEC (1..15) LED hold ticks, UNIT_W change width.
module vend_dispense #(
  parameter int HOLD_SEC = 2,
  parameter int UNIT_W   = 3
) (
  input  logic           clk_1Hz,
  input  logic           clr,
  vend_dispense_if.slave bus
);

  import vend_pkg::*;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_SEC - 1);

  vend_state_t       state_q, state_n;
  logic [3:0]        hold_q, hold_n;
  logic [UNIT_W-1:0] rem_q, rem_n;
  logic [3:0]        led_q, led_n;
  logic              busy_q, busy_n;
  logic [2:0]        coin_q, coin_n;
  logic [7:0]        left_q, left_n;
  logic              done_q, done_n;
  logic              err_q, err_n;

  logic [2:0]        sel_coin;
  logic [UNIT_W-1:0] sel_rem;

  change_coin_sel #(
    .UNIT_W (UNIT_W)
  ) u_coin_sel (
    .rem      (rem_q),
    .coin_sel (sel_coin),
    .rem_next (sel_rem)
  );

  always_ff @(posedge clk_1Hz or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      rem_q   <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      coin_q  <= '0;
      left_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      hold_q  <= hold_n;
      rem_q   <= rem_n;
      led_q   <= led_n;
      busy_q  <= busy_n;
      coin_q  <= coin_n;
      left_q  <= left_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  // Coin and done registers default to 0 so they only ever pulse for the
  // single tick following the edge that set them.
  always_comb begin
    state_n = state_q;
    hold_n  = hold_q;
    rem_n   = rem_q;
    led_n   = led_q;
    busy_n  = busy_q;
    coin_n  = COIN_SEL_NONE;
    left_n  = left_q;
    done_n  = 1'b0;
    err_n   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.vend_req) begin
          if (is_onehot4(bus.item)) begin
            led_n   = bus.item;
            rem_n   = bus.change_units;
            hold_n  = HOLD_LOAD;
            busy_n  = 1'b1;
            left_n  = units_to_cents(8'(bus.change_units));
            state_n = ST_VEND;
          end else begin
            err_n = 1'b1;
          end
        end
      end

      ST_VEND: begin
        if (bus.vend_req) err_n = 1'b1;
        if (hold_q != 4'd0) begin
          hold_n = hold_q - 4'd1;
        end else begin
          led_n = '0;
          if (rem_q == '0) begin
            state_n = ST_DONE;
            done_n  = 1'b1;
          end else begin
            state_n = ST_CHANGE;
          end
        end
      end

      // The coin that empties rem is registered on the same edge as done,
      // so the last coin pulse lands in the DONE tick.
      ST_CHANGE: begin
        if (bus.vend_req) err_n = 1'b1;
        coin_n = sel_coin;
        rem_n  = sel_rem;
        left_n = units_to_cents(8'(sel_rem));
        if (sel_rem == '0) begin
          state_n = ST_DONE;
          done_n  = 1'b1;
        end
      end

      ST_DONE: begin
        if (bus.vend_req) err_n = 1'b1;
        state_n = ST_IDLE;
        busy_n  = 1'b0;
        left_n  = '0;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign bus.busy        = busy_q;
  assign bus.led         = led_q;
  assign bus.coin5       = coin_q[0];
  assign bus.coin10      = coin_q[1];
  assign bus.coin25      = coin_q[2];
  assign bus.change_left = left_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule
